instr_encoder: RTL and testbench

Packs RISC-V I-type and S-type instruction fields, including a sign-extended 32-bit immediate, into 32-bit instruction words. Writes them sequentially into a word-addressed instruction memory. It is the inverse of the immediate sign-extender in the datapath: words it produces must decode back to the same fields and immediate. It sits in the program-loader path, between a host/UART command stream and the instruction memory write port.

---
 rtl/instr_encoder_if.sv | 36 +++
 rtl/instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
// master = host/loader side, slave = encoder side.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic              in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport master (
        output clr, in_valid, in_fmt, in_opcode, in_funct3,
        output in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  count, full, err
    );

    modport slave (
        input  clr, in_valid, in_fmt, in_opcode, in_funct3,
        input  in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output count, full, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs RISC-V I/S-type fields into words and writes them to instruction memory.
// Define IMM_RANGE_CHECK_EN to reject immediates outside -2048..2047 (sets err).
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ENC,
        WR
    } state_e;

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic              fmt_q, fmt_d;
    logic [6:0]        op_q, op_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [11:0]       imm_q, imm_d;
    logic              imm_ok_q, imm_ok_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              full;
    logic              ready;
    logic              hs;
    logic              imm_ok_in;
    logic [31:0]       word;

`ifdef IMM_RANGE_CHECK_EN
    // In range iff bits 31..11 are all copies of the sign bit.
    assign imm_ok_in = (bus.in_imm[31:11] == {21{bus.in_imm[11]}});
`else
    logic unused_imm_hi;
    assign imm_ok_in     = 1'b1;
    assign unused_imm_hi = ^bus.in_imm[31:12];
`endif

    assign full  = (cnt_q == CAP);
    assign ready = (state_q == IDLE) && !full;
    assign hs    = bus.in_valid && ready;

    always_comb begin
        word = {imm_q, rs1_q, f3_q, rd_q, op_q};
        if (fmt_q) begin
            word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        end
    end

    always_comb begin
        state_d  = state_q;
        fmt_d    = fmt_q;
        op_d     = op_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        imm_ok_d = imm_ok_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (bus.clr) begin
            state_d = IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        fmt_d    = bus.in_fmt;
                        op_d     = bus.in_opcode;
                        f3_d     = bus.in_funct3;
                        rd_d     = bus.in_rd;
                        rs1_d    = bus.in_rs1;
                        rs2_d    = bus.in_rs2;
                        imm_d    = bus.in_imm[11:0];
                        imm_ok_d = imm_ok_in;
                        state_d  = ENC;
                    end
                end
                ENC: begin
                    if (!imm_ok_q) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word;
                        state_d = WR;
                    end
                end
                WR: begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + (ADDR_W + 1)'(1);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fmt_q    <= 1'b0;
            op_q     <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            imm_ok_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fmt_q    <= fmt_d;
            op_q     <= op_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            imm_ok_q <= imm_ok_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = cnt_q;
    assign bus.full      = full;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder (ADDR_W=2).
// Expected words come from field arithmetic, not from the RTL structure.
module tb_instr_encoder;
    localparam int AW  = 2;
    localparam int CAP = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW)) ifc ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          exp_ptr;
    int          exp_cnt;
    bit          exp_err;
    logic [31:0] last_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input bit fmt, input int op,
        input int f3, input int rd, input int rs1, input int rs2,
        input logic [31:0] imm);
        longint lo12;
        longint r;
        lo12 = longint'(imm) % 4096;
        if (!fmt)
            r = lo12 * (2 ** 20) + rs1 * (2 ** 15) + f3 * 4096
                + rd * 128 + op;
        else
            r = (lo12 / 32) * (2 ** 25) + rs2 * (2 ** 20)
                + rs1 * (2 ** 15) + f3 * 4096 + (lo12 % 32) * 128 + op;
        return 32'(r);
    endfunction

    function automatic logic [31:0] decode_s(input logic [31:0] w);
        int v;
        v = int'(w / (2 ** 25)) * 32 + int'((w / 128) % 32);
        if (v >= 2048) v -= 4096;
        return 32'(v);
    endfunction

    function automatic bit writes(input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
        return (s >= -2048) && (s <= 2047);
`else
        return (imm === imm);
`endif
    endfunction

    task automatic model_clear();
        exp_ptr = 0;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    // mode 0: normal, 1: clr during ENC, 2: rst during WR
    task automatic send(input bit fmt, input int op, input int f3,
        input int rd, input int rs1, input int rs2,
        input logic [31:0] imm, input int mode);
        bit          ok;
        bit          pass;
        logic [31:0] w;
        ifc.in_fmt    = fmt;
        ifc.in_opcode = 7'(op);
        ifc.in_funct3 = 3'(f3);
        ifc.in_rd     = 5'(rd);
        ifc.in_rs1    = 5'(rs1);
        ifc.in_rs2    = 5'(rs2);
        ifc.in_imm    = imm;
        ifc.in_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ifc.in_ready;
        end
        if (!ok) begin
            check_eq("ready_timeout", 32'(ifc.in_ready), 32'd1);
            ifc.in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        w    = encode(fmt, op, f3, rd, rs1, rs2, imm);
        pass = writes(imm);
        if (mode == 1) begin
            ifc.clr = 1'b1;
            @(posedge clk); #1;
            ifc.clr = 1'b0;
            model_clear();
            @(negedge clk);
            check_eq("clr_enc_we", 32'(ifc.mem_we), 32'd0);
            check_eq("clr_enc_ready", 32'(ifc.in_ready), 32'd1);
            check_eq("clr_enc_count", 32'(ifc.count), 32'd0);
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        check_eq("enc_ready", 32'(ifc.in_ready), 32'd0);
        check_eq("enc_we", 32'(ifc.mem_we), 32'd0);
        @(negedge clk);
        if (pass) begin
            check_eq("wr_we", 32'(ifc.mem_we), 32'd1);
            check_eq("wr_addr", 32'(ifc.mem_addr), 32'(exp_ptr));
            check_eq("wr_data", ifc.mem_wdata, w);
            check_eq("wr_ready", 32'(ifc.in_ready), 32'd0);
            last_wdata = ifc.mem_wdata;
            if (mode == 2) begin
                rst = 1'b1;
                #1;
                check_eq("rst_we", 32'(ifc.mem_we), 32'd0);
                check_eq("rst_addr", 32'(ifc.mem_addr), 32'd0);
                check_eq("rst_data", ifc.mem_wdata, 32'd0);
                check_eq("rst_count", 32'(ifc.count), 32'd0);
                check_eq("rst_full", 32'(ifc.full), 32'd0);
                check_eq("rst_err", 32'(ifc.err), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                model_clear();
                @(negedge clk);
                check_eq("rst_ready", 32'(ifc.in_ready), 32'd1);
                @(posedge clk); #1;
                return;
            end
            exp_ptr = (exp_ptr + 1) % CAP;
            exp_cnt++;
            @(negedge clk);
            check_eq("post_we", 32'(ifc.mem_we), 32'd0);
        end else begin
            check_eq("rej_we", 32'(ifc.mem_we), 32'd0);
            exp_err = 1'b1;
        end
        check_eq("count", 32'(ifc.count), 32'(exp_cnt));
        check_eq("full", 32'(ifc.full), 32'(exp_cnt == CAP));
        check_eq("err", 32'(ifc.err), 32'(exp_err));
        check_eq("ready", 32'(ifc.in_ready), 32'(exp_cnt != CAP));
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        ifc.clr = 1'b1;
        @(posedge clk); #1;
        ifc.clr = 1'b0;
        model_clear();
        @(negedge clk);
        check_eq("clr_count", 32'(ifc.count), 32'd0);
        check_eq("clr_full", 32'(ifc.full), 32'd0);
        check_eq("clr_err", 32'(ifc.err), 32'd0);
        check_eq("clr_ready", 32'(ifc.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        logic [31:0] edges [6];
        edges = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF,
                  32'h0, 32'hFFFFFFFF};
        r = $urandom;
        case ($urandom % 4)
            0: return r;
            3: return edges[$urandom % 6];
            default: return {{20{r[11]}}, r[11:0]};
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        ifc.clr       = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_fmt    = 1'b0;
        ifc.in_opcode = '0;
        ifc.in_funct3 = '0;
        ifc.in_rd     = '0;
        ifc.in_rs1    = '0;
        ifc.in_rs2    = '0;
        ifc.in_imm    = '0;
        last_wdata    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst0_we", 32'(ifc.mem_we), 32'd0);
        check_eq("rst0_addr", 32'(ifc.mem_addr), 32'd0);
        check_eq("rst0_data", ifc.mem_wdata, 32'd0);
        check_eq("rst0_count", 32'(ifc.count), 32'd0);
        check_eq("rst0_full", 32'(ifc.full), 32'd0);
        check_eq("rst0_err", 32'(ifc.err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst0_ready", 32'(ifc.in_ready), 32'd1);
        @(posedge clk); #1;

        send(0, 'h13, 0, 1, 0, 0, 32'd5, 0);
        check_eq("addi_word", last_wdata, 32'h00500093);
        send(1, 'h23, 2, 0, 3, 2, 32'hFFFFFFFC, 0);
        check_eq("sw_word", last_wdata, 32'hFE21AE23);
        check_eq("sw_decode", decode_s(last_wdata), 32'hFFFFFFFC);
        send(0, 'h03, 2, 5, 6, 0, 32'hFFFFFFFF, 0);
        check_eq("lw_word", last_wdata, 32'hFFF32283);

        do_clr();
        send(0, 'h13, 0, 7, 0, 0, 32'h00000800, 0);
`ifndef IMM_RANGE_CHECK_EN
        check_eq("imm800_word", last_wdata, 32'h80000393);
`endif
        send(0, 'h13, 0, 2, 0, 0, 32'd7, 0);

        do_clr();
        for (int i = 0; i < CAP; i++)
            send(0, 'h13, 0, i + 1, 0, 0, 32'(i), 0);
        ifc.in_fmt    = 1'b1;
        ifc.in_opcode = 7'h23;
        ifc.in_funct3 = 3'd2;
        ifc.in_rs1    = 5'd9;
        ifc.in_rs2    = 5'd4;
        ifc.in_imm    = 32'd40;
        ifc.in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("stall_ready", 32'(ifc.in_ready), 32'd0);
            check_eq("stall_we", 32'(ifc.mem_we), 32'd0);
        end
        @(posedge clk); #1;
        ifc.clr = 1'b1;
        @(posedge clk); #1;
        ifc.clr = 1'b0;
        model_clear();
        send(1, 'h23, 2, 0, 9, 4, 32'd40, 0);

        send(0, 'h13, 1, 3, 4, 0, 32'd12, 1);
        send(1, 'h23, 0, 0, 5, 6, 32'hFFFFFF00, 2);

        for (int i = 0; i < 80; i++) begin
            if (exp_cnt == CAP || ($urandom % 10) == 0) do_clr();
            send(1'($urandom), int'($urandom % 128), int'($urandom % 8),
                 int'($urandom % 32), int'($urandom % 32),
                 int'($urandom % 32), rand_imm(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
